// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: multi-cycle BCD-to-binary converter (reverse double-dabble).
// Each SHIFT cycle shifts {bcd, bin} right by one. Any BCD digit that is 8 or
// more after the shift then has 3 subtracted. After NBIN cycles the bin
// register holds the result.
// Optional feature: define BCD2BIN_ERR_EN to reject operands that contain a
// digit above 9. A rejected operand completes in one cycle with err_o set.
module bcd_to_binary_seq #(
    parameter int NDIG = 6,
    parameter int NBIN = 20
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start_i,
    input  logic [4*NDIG-1:0]      bcd_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [NBIN-1:0]        bin_o,
    output logic                   err_o
);

    localparam int CW = $clog2(NBIN + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_stateNext;
    logic [4*NDIG-1:0]        r_bcdSh;
    logic [NBIN-1:0]          r_binSh;
    logic [NBIN-1:0]          r_bin;
    logic [CW-1:0]            r_cnt;
    logic [CW-1:0]            w_cntNext;
    logic [4*NDIG+NBIN-1:0]   w_shifted;
    logic [4*NDIG-1:0]        w_bcdShifted;
    logic [4*NDIG-1:0]        w_bcdAdj;
    logic [NBIN-1:0]          w_binShifted;
    logic                     w_last;
    logic                     w_badDigit;

    assign w_shifted    = {r_bcdSh, r_binSh} >> 1;
    assign w_bcdShifted = w_shifted[4*NDIG+NBIN-1:NBIN];
    assign w_binShifted = w_shifted[NBIN-1:0];
    assign w_cntNext    = r_cnt + CW'(1);
    assign w_last       = (w_cntNext == CW'(NBIN));
    assign bin_o        = r_bin;

    // Digit correction: each shifted digit that is 8 or more loses 3, with no borrow between digits
    always_comb begin
        w_bcdAdj = w_bcdShifted;
        for (int k = 0; k < NDIG; k++) begin
            if (w_bcdShifted[4*k+3]) begin
                w_bcdAdj[4*k +: 4] = w_bcdShifted[4*k +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD2BIN_ERR_EN
    logic r_err;

    // Flag an incoming operand that contains any digit above 9
    always_comb begin
        w_badDigit = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (bcd_i[4*k +: 4] > 4'd9) begin
                w_badDigit = 1'b1;
            end
        end
    end

    // The error flag is updated only when a start is accepted, and it holds until the next accepted start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else if (start_i && (r_state != SHIFT)) begin
            r_err <= w_badDigit;
        end
    end

    assign err_o = r_err;
`else
    assign w_badDigit = 1'b0;
    assign err_o      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and status outputs; DONE also accepts a start, so back-to-back runs skip IDLE
    always_comb begin
        w_stateNext = r_state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                done_o = (r_state == DONE);
                if (start_i) begin
                    w_stateNext = w_badDigit ? DONE : SHIFT;
                end else begin
                    w_stateNext = IDLE;
                end
            end
            SHIFT: begin
                busy_o = 1'b1;
                if (w_last) begin
                    w_stateNext = DONE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Datapath: load on an accepted start, iterate in SHIFT, and publish the result on the last iteration
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bcdSh <= '0;
            r_binSh <= '0;
            r_bin   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start_i && !w_badDigit) begin
                        r_bcdSh <= bcd_i;
                        r_binSh <= '0;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_bcdSh <= w_bcdAdj;
                    r_binSh <= w_binShifted;
                    r_cnt   <= w_cntNext;
                    if (w_last) begin
                        r_bin <= w_binShifted;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
